// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG7_HEX   : active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
//   MAX_DIGITS : number of anodes on the board display
//   disp_state_e : scan FSM states
package disp_pkg;

   localparam int unsigned MAX_DIGITS = 8;

   localparam logic [6:0] SEG7_HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StBlank,
      StShow
   } disp_state_e;

endpackage

// File: rtl/disp_scan_driver_if.sv
// Display bus from the register file to the scan driver.
//   disp_data : seven 4-bit nibbles, digit 0 at bits [3:0]
//   enable    : 1 = scan, 0 = display dark
//   lz_blank  : 1 = suppress leading zeros
// master = register-file side (drives), slave = scan driver (reads).
interface disp_scan_driver_if;

   logic [27:0] disp_data;
   logic        enable;
   logic        lz_blank;

   modport master (output disp_data, output enable, output lz_blank);
   modport slave  (input disp_data, input enable, input lz_blank);

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex value
//   seg_n  : active-low cathodes {g,f,e,d,c,b,a}
module hex_to_seg7
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = SEG7_HEX[nibble];

endmodule

// File: rtl/disp_scan_driver.sv
// Time-multiplexed seven-segment driver. Snapshots the display bus once per
// frame, then scans each digit with a blank gap at the start of every slot.
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : display bus (slave modport): disp_data, enable, lz_blank
//   seg_n      : cathodes, active low, {g,f,e,d,c,b,a}
//   dp_n       : decimal point, active low, tied off
//   an_n       : anodes, active low, one-hot-low when lit
//   frame_tick : one-cycle pulse on each snapshot load
module disp_scan_driver
   import disp_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 7,
   parameter int unsigned SCAN_DIV     = 16384,
   parameter int unsigned BLANK_CYCLES = 512
) (
   input  logic                      clock,
   input  logic                      reset_n,
   disp_scan_driver_if.slave         bus,
   output logic [6:0]                seg_n,
   output logic                      dp_n,
   output logic [MAX_DIGITS-1:0]     an_n,
   output logic                      frame_tick
);

   localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_DIV - 1);
   localparam logic [2:0]        DIGIT_LAST = 3'(NUM_DIGITS - 1);

   disp_state_e          state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [2:0]           digit_q, digit_d;
   logic [27:0]          snap_q;
   logic                 load_snap;
   logic [6:0]           seg_q, seg_d;
   logic [MAX_DIGITS-1:0] an_q, an_d;

   // ---------------------------------------------------------------------
   // Scan FSM and counters
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      digit_d   = digit_q;
      load_snap = 1'b0;

      unique case (state_q)
         StIdle: begin
            tick_d  = '0;
            digit_d = '0;
            state_d = StLoad;
         end
         StLoad: begin
            // The load cycle is tick 0 of the digit-0 slot.
            load_snap = 1'b1;
            digit_d   = '0;
            tick_d    = TICK_W'(1);
            state_d   = (32'(tick_d) < BLANK_CYCLES) ? StBlank : StShow;
         end
         StBlank, StShow: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (digit_q == DIGIT_LAST) begin
                  digit_d = '0;
                  state_d = StLoad;
               end else begin
                  digit_d = 3'(digit_q + 3'd1);
                  state_d = (BLANK_CYCLES > 0) ? StBlank : StShow;
               end
            end else begin
               tick_d  = TICK_W'(tick_q + TICK_W'(1));
               state_d = (32'(tick_d) < BLANK_CYCLES) ? StBlank : StShow;
            end
         end
         default: state_d = StIdle;
      endcase

      // Disabling overrides everything and parks the scan.
      if (!bus.enable) begin
         state_d   = StIdle;
         tick_d    = '0;
         digit_d   = '0;
         load_snap = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         tick_q  <= '0;
         digit_q <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         digit_q <= digit_d;
         if (load_snap) snap_q <= bus.disp_data;
      end
   end

   assign frame_tick = load_snap;

   // ---------------------------------------------------------------------
   // Leading-zero mask: digit k blanks when every nibble at or above k is 0
   // ---------------------------------------------------------------------
   logic [4*MAX_DIGITS-1:0] snap_ext;
   logic [MAX_DIGITS-1:0]   lz_mask;
   logic                    zero_above;

   // Unused top nibble reads as zero so an 8-digit scan stays in range.
   assign snap_ext = {{(4*MAX_DIGITS-28){1'b0}}, snap_q};

   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int k = int'(MAX_DIGITS) - 1; k >= 0; k--) begin
         zero_above = zero_above & (snap_ext[4*k +: 4] == 4'h0);
         lz_mask[k] = zero_above & (k != 0);
      end
   end

   // ---------------------------------------------------------------------
   // Registered display outputs (one clock behind the counters)
   // ---------------------------------------------------------------------
   logic [3:0] cur_nibble;
   logic [6:0] cur_glyph;

   assign cur_nibble = snap_ext[4*digit_q +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (cur_nibble),
      .seg_n  (cur_glyph)
   );

   always_comb begin
      an_d  = '1;
      seg_d = 7'h7F;
      if (bus.enable && (state_q == StShow)) begin
         an_d[digit_q] = 1'b0;
         seg_d         = (bus.lz_blank && lz_mask[digit_q]) ? 7'h7F : cur_glyph;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         an_q  <= '1;
         seg_q <= 7'h7F;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign an_n  = an_q;
   assign seg_n = seg_q;
   assign dp_n  = 1'b1;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Directed bench for disp_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2,
// NUM_DIGITS=7. Offsets k below count negedges after a frame_tick sample:
// digit d is lit for k in [8d+3, 8d+8] (2 blank clocks + 1 output lag).
module tb_disp_scan_driver;

   localparam int unsigned ND = 7;
   localparam int unsigned SD = 8;
   localparam int unsigned BC = 2;

   localparam logic [6:0] G0  = 7'b1000000;
   localparam logic [6:0] G1  = 7'b1111001;
   localparam logic [6:0] G2  = 7'b0100100;
   localparam logic [6:0] G3  = 7'b0110000;
   localparam logic [6:0] G4  = 7'b0011001;
   localparam logic [6:0] G5  = 7'b0010010;
   localparam logic [6:0] G6  = 7'b0000010;
   localparam logic [6:0] GA  = 7'b0001000;
   localparam logic [6:0] BLK = 7'h7F;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [7:0] an_n;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   logic [6:0] g [7];

   disp_scan_driver_if bus ();

   disp_scan_driver #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .bus        (bus),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .frame_tick (frame_tick)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_load(input string tag);
      int n;
      n = 0;
      while (frame_tick !== 1'b1 && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk(tag, {7'd0, frame_tick}, 8'd1);
   endtask

   // Walk offsets 1..last_k of a frame, checking every output each clock.
   // New bus data is applied at k=20 (mid-frame); new lz_blank at k=56.
   task automatic run_frame(input string tag, input int last_k,
                            input logic [27:0] nd, input logic nlz);
      int         d;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      for (int k = 1; k <= last_k; k++) begin
         @(negedge clock);
         if (k >= 3 && ((k - 3) % 8) < 6) begin
            d       = (k - 3) / 8;
            exp_an  = ~(8'd1 << d);
            exp_seg = g[d];
         end else begin
            exp_an  = 8'hFF;
            exp_seg = BLK;
         end
         chk($sformatf("%s an_n k=%0d", tag, k), an_n, exp_an);
         chk($sformatf("%s seg_n k=%0d", tag, k), {1'b0, seg_n}, {1'b0, exp_seg});
         chk($sformatf("%s frame_tick k=%0d", tag, k), {7'd0, frame_tick},
             (k == 56) ? 8'd1 : 8'd0);
         if (k == 10) chk($sformatf("%s dp_n", tag), {7'd0, dp_n}, 8'd1);
         if (k == 20) bus.disp_data = nd;
         if (k == 56) bus.lz_blank = nlz;
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.enable    = 1'b1;
      bus.disp_data = 28'h6543210;
      bus.lz_blank  = 1'b0;

      // Reset held with enable high
      repeat (3) @(negedge clock);
      chk("reset an_n", an_n, 8'hFF);
      chk("reset seg_n", {1'b0, seg_n}, 8'h7F);
      chk("reset dp_n", {7'd0, dp_n}, 8'd1);
      chk("reset frame_tick", {7'd0, frame_tick}, 8'd0);

      reset_n = 1'b1;
      wait_load("first load");

      // Scan order, no blanking
      g = '{G0, G1, G2, G3, G4, G5, G6};
      run_frame("scan", 56, 28'h0000A03, 1'b1);

      // Leading-zero blanking
      g = '{G3, G0, GA, BLK, BLK, BLK, BLK};
      run_frame("lz", 56, 28'h0000000, 1'b1);

      g = '{G0, BLK, BLK, BLK, BLK, BLK, BLK};
      run_frame("lz zero", 56, 28'h1111111, 1'b0);

      // Snapshot stability: data changes to 2s at k=20, frame keeps 1s
      g = '{G1, G1, G1, G1, G1, G1, G1};
      run_frame("snap ones", 56, 28'h2222222, 1'b0);

      // Disable during digit-3 SHOW
      g = '{G2, G2, G2, G2, G2, G2, G2};
      run_frame("snap twos", 28, 28'h2222222, 1'b0);
      bus.enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk($sformatf("disabled an_n %0d", i), an_n, 8'hFF);
         chk($sformatf("disabled seg_n %0d", i), {1'b0, seg_n}, 8'h7F);
         chk($sformatf("disabled frame_tick %0d", i), {7'd0, frame_tick}, 8'd0);
      end
      bus.enable = 1'b1;
      wait_load("reenable load");

      // Restart at digit 0, then async reset during digit-3 SHOW
      run_frame("restart", 30, 28'h2222222, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("async an_n", an_n, 8'hFF);
      chk("async seg_n", {1'b0, seg_n}, 8'h7F);
      chk("async frame_tick", {7'd0, frame_tick}, 8'd0);
      @(negedge clock);
      chk("async held an_n", an_n, 8'hFF);
      reset_n = 1'b1;
      wait_load("post reset load");
      run_frame("after reset", 56, 28'h2222222, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
